// File: rtl/fetch_insn_queue.sv
// ---------------------------------------------------------------------------
// fetch_insn_queue
//
// Decoupling queue between the fetch stage and pre-decode. Each cycle it
// accepts up to FETCH_WIDTH instructions under an arbitrary lane-valid mask
// and packs them contiguously in lane order. It presents up to DECODE_WIDTH
// of the oldest entries. A flush drops every entry.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   flush         discard all entries (front-end redirect)
//   inValid       per-lane valid mask of the fetch group, any pattern
//   inInsn        fetch lane i at [i*INSN_WIDTH +: INSN_WIDTH]
//   inPC          fetch lane i at [i*PC_WIDTH +: PC_WIDTH]
//   inPredTaken   per-lane predicted-taken bit
//   inReady       room for a full fetch group (from registered count only)
//   outValid      thermometer code, lane j valid iff count > j
//   outInsn       oldest-first instruction words
//   outPC         oldest-first PCs
//   outPredTaken  oldest-first predicted-taken bits
//   outAccept     number of output lanes consumed this cycle
//   count         current occupancy
//   protocolErr   sticky flag for enqueue-when-not-ready or over-accept
// ---------------------------------------------------------------------------
module fetch_insn_queue #(
    parameter int FETCH_WIDTH  = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = 8,
    parameter int INSN_WIDTH   = 32,
    parameter int PC_WIDTH     = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [FETCH_WIDTH-1:0]                inValid,
    input  logic [FETCH_WIDTH*INSN_WIDTH-1:0]     inInsn,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0]       inPC,
    input  logic [FETCH_WIDTH-1:0]                inPredTaken,
    output logic                                  inReady,
    output logic [DECODE_WIDTH-1:0]               outValid,
    output logic [DECODE_WIDTH*INSN_WIDTH-1:0]    outInsn,
    output logic [DECODE_WIDTH*PC_WIDTH-1:0]      outPC,
    output logic [DECODE_WIDTH-1:0]               outPredTaken,
    input  logic [$clog2(DECODE_WIDTH+1)-1:0]     outAccept,
    output logic [$clog2(DEPTH+1)-1:0]            count,
    output logic                                  protocolErr
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int ACC_W  = $clog2(DECODE_WIDTH+1);
    localparam int FCNT_W = $clog2(FETCH_WIDTH+1);

    // Payload storage (not reset)
    logic [INSN_WIDTH-1:0] r_mem_insn [DEPTH];
    logic [PC_WIDTH-1:0]   r_mem_pc   [DEPTH];
    logic                  r_mem_pt   [DEPTH];

    // Control state
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_perr;

    logic [FCNT_W-1:0] w_lane_off [FETCH_WIDTH];
    logic [FCNT_W-1:0] w_in_pop;
    logic              w_in_ready;
    logic              w_enq;
    logic              w_enq_err;
    logic [ACC_W-1:0]  w_avail;
    logic              w_acc_err;
    logic [ACC_W-1:0]  w_deq;
    logic [PTR_W-1:0]  w_rd_idx;

    // Each valid lane lands at tail + (number of valid lanes below it),
    // which packs the group densely without any gaps.
    always_comb begin
        w_in_pop = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_lane_off[i] = w_in_pop;
            w_in_pop      = w_in_pop + FCNT_W'(inValid[i]);
        end
    end

    // Ready looks only at the registered count, so a same-cycle dequeue
    // never creates a path from outAccept to inReady.
    assign w_in_ready = (r_count <= CNT_W'(DEPTH - FETCH_WIDTH));
    assign w_enq      = w_in_ready && !flush && (|inValid);
    assign w_enq_err  = (|inValid) && !w_in_ready && !flush;

    // Over-accept is flagged and clamped to what is actually presented.
    assign w_avail   = (r_count >= CNT_W'(DECODE_WIDTH)) ? ACC_W'(DECODE_WIDTH)
                                                          : ACC_W'(r_count);
    assign w_acc_err = (outAccept > w_avail);
    assign w_deq     = w_acc_err ? w_avail : outAccept;

    // Output lanes read straight from storage; no enqueue bypass.
    always_comb begin
        outValid     = '0;
        outInsn      = '0;
        outPC        = '0;
        outPredTaken = '0;
        w_rd_idx     = '0;
        for (int j = 0; j < DECODE_WIDTH; j++) begin
            w_rd_idx = r_head + PTR_W'(j);
            outValid[j]                          = (r_count > CNT_W'(j));
            outInsn[j*INSN_WIDTH +: INSN_WIDTH]  = r_mem_insn[w_rd_idx];
            outPC[j*PC_WIDTH +: PC_WIDTH]        = r_mem_pc[w_rd_idx];
            outPredTaken[j]                      = r_mem_pt[w_rd_idx];
        end
    end

    assign inReady     = w_in_ready;
    assign count       = r_count;
    assign protocolErr = r_perr;

    // Control registers: rst beats flush, flush beats traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_perr  <= 1'b0;
        end else begin
            if (w_enq_err || w_acc_err)
                r_perr <= 1'b1;
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head <= r_head + PTR_W'(w_deq);
                if (w_enq)
                    r_tail <= r_tail + PTR_W'(w_in_pop);
                r_count <= r_count - CNT_W'(w_deq)
                         + (w_enq ? CNT_W'(w_in_pop) : CNT_W'(0));
            end
        end
    end

    // Payload write: only valid lanes of an accepted group.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (inValid[i]) begin
                    r_mem_insn[r_tail + PTR_W'(w_lane_off[i])] <= inInsn[i*INSN_WIDTH +: INSN_WIDTH];
                    r_mem_pc[r_tail + PTR_W'(w_lane_off[i])]   <= inPC[i*PC_WIDTH +: PC_WIDTH];
                    r_mem_pt[r_tail + PTR_W'(w_lane_off[i])]   <= inPredTaken[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_insn_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_insn_queue
//
// Directed bench for fetch_insn_queue (FETCH_WIDTH=2, DECODE_WIDTH=2,
// DEPTH=8). A queue-based reference model tracks the expected contents and
// is compared against the DUT on every falling edge; hand-computed literal
// checks pin the model at key points of each scenario.
// ---------------------------------------------------------------------------
module tb_fetch_insn_queue;

    localparam int FW    = 2;
    localparam int DW    = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    inValid = '0;
    logic [63:0]   inInsn = '0;
    logic [63:0]   inPC = '0;
    logic [1:0]    inPredTaken = '0;
    logic          inReady;
    logic [1:0]    outValid;
    logic [63:0]   outInsn;
    logic [63:0]   outPC;
    logic [1:0]    outPredTaken;
    logic [1:0]    outAccept = '0;
    logic [3:0]    count;
    logic          protocolErr;

    fetch_insn_queue #(
        .FETCH_WIDTH (FW),
        .DECODE_WIDTH(DW),
        .DEPTH       (DEPTH),
        .INSN_WIDTH  (32),
        .PC_WIDTH    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .inValid     (inValid),
        .inInsn      (inInsn),
        .inPC        (inPC),
        .inPredTaken (inPredTaken),
        .inReady     (inReady),
        .outValid    (outValid),
        .outInsn     (outInsn),
        .outPC       (outPC),
        .outPredTaken(outPredTaken),
        .outAccept   (outAccept),
        .count       (count),
        .protocolErr (protocolErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        pt;
    } ent_t;

    ent_t mq[$];
    bit   merr = 1'b0;
    bit   started = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] pcf(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ 32'h0000_4000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per clock edge, from the inputs of that edge.
    task automatic model_step(input bit r, input bit fl, input logic [1:0] iv,
                              input logic [31:0] a, input logic [31:0] b,
                              input int acc);
        int   sz;
        int   vc;
        int   k;
        bit   rdy;
        ent_t e;
        if (r) begin
            mq.delete();
            merr = 1'b0;
            return;
        end
        sz  = mq.size();
        vc  = (sz < DW) ? sz : DW;
        rdy = (DEPTH - sz) >= FW;
        if (iv != 2'b00 && !rdy && !fl) merr = 1'b1;
        if (acc > vc) merr = 1'b1;
        if (fl) begin
            mq.delete();
        end else begin
            k = (acc > vc) ? vc : acc;
            repeat (k) void'(mq.pop_front());
            if (rdy && iv != 2'b00) begin
                for (int l = 0; l < FW; l++) begin
                    if (iv[l]) begin
                        e.insn = (l == 0) ? a : b;
                        e.pc   = pcf(e.insn);
                        e.pt   = ^e.insn;
                        mq.push_back(e);
                    end
                end
            end
        end
    endtask

    // Drive one cycle, advance the model at the edge, then return to idle.
    task automatic go(input bit r, input bit fl, input logic [1:0] iv,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] acc);
        rst         = r;
        flush       = fl;
        inValid     = iv;
        inInsn      = {b, a};
        inPC        = {pcf(b), pcf(a)};
        inPredTaken = {^b, ^a};
        outAccept   = acc;
        @(posedge clk);
        model_step(r, fl, iv, a, b, int'(acc));
        if (r) started = 1'b1;
        #1;
        rst       = 1'b0;
        flush     = 1'b0;
        inValid   = '0;
        outAccept = '0;
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            int   sz;
            logic [1:0] ev;
            sz = mq.size();
            ev = (sz >= 2) ? 2'b11 : ((sz == 1) ? 2'b01 : 2'b00);
            chk("m_count", 64'(count), 64'(sz));
            chk("m_inReady", 64'(inReady), 64'((DEPTH - sz) >= FW));
            chk("m_outValid", 64'(outValid), 64'(ev));
            chk("m_protocolErr", 64'(protocolErr), 64'(merr));
            for (int j = 0; j < DW; j++) begin
                if (j < sz) begin
                    chk("m_outInsn", 64'(outInsn[j*32 +: 32]), 64'(mq[j].insn));
                    chk("m_outPC", 64'(outPC[j*32 +: 32]), 64'(mq[j].pc));
                    chk("m_outPT", 64'(outPredTaken[j]), 64'(mq[j].pt));
                end
            end
        end
    end

    initial begin
        int sz;
        int vc;
        logic [1:0]  iv;
        logic [1:0]  acc;
        logic [31:0] ser;

        // 1. Reset, then a full group A,B
        go(1, 0, 2'b00, 0, 0, 0);
        go(1, 0, 2'b00, 0, 0, 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_outValid", 64'(outValid), 0);
        chk("rst_inReady", 64'(inReady), 1);
        chk("rst_perr", 64'(protocolErr), 0);
        go(0, 0, 2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 0);
        chk("t1_outValid", 64'(outValid), 64'h3);
        chk("t1_lane0", 64'(outInsn[31:0]), 64'hAAAA_0001);
        chk("t1_lane1", 64'(outInsn[63:32]), 64'hBBBB_0002);
        chk("t1_pc0", 64'(outPC[31:0]), 64'h0001_EAAA);
        chk("t1_count", 64'(count), 2);

        // 2. Compaction: lane 1 alone lands at the head
        go(0, 0, 2'b00, 0, 0, 2);
        go(0, 0, 2'b10, 32'hDEAD_0000, 32'h1234_5678, 0);
        chk("t2_outValid", 64'(outValid), 64'h1);
        chk("t2_lane0", 64'(outInsn[31:0]), 64'h1234_5678);
        chk("t2_count", 64'(count), 1);
        go(0, 0, 2'b00, 0, 0, 1);

        // 3. Fill to DEPTH, then overflow attempt
        for (int g = 0; g < 4; g++)
            go(0, 0, 2'b11, 32'hF000_0000 + 32'(2*g), 32'hF000_0001 + 32'(2*g), 0);
        chk("t3_count_full", 64'(count), 8);
        chk("t3_inReady", 64'(inReady), 0);
        chk("t3_lane0", 64'(outInsn[31:0]), 64'hF000_0000);
        go(0, 0, 2'b11, 32'hEEEE_0000, 32'hEEEE_0001, 0);
        chk("t3_perr", 64'(protocolErr), 1);
        chk("t3_count_hold", 64'(count), 8);
        chk("t3_lane1", 64'(outInsn[63:32]), 64'hF000_0001);
        go(1, 0, 2'b00, 0, 0, 0);
        chk("t3_rst_perr", 64'(protocolErr), 0);

        // 4. Concurrent traffic around the full boundary and through wrap
        go(0, 0, 2'b11, 32'h4000_0000, 32'h4000_0001, 0);
        go(0, 0, 2'b11, 32'h4000_0002, 32'h4000_0003, 0);
        go(0, 0, 2'b11, 32'h4000_0004, 32'h4000_0005, 0);
        go(0, 0, 2'b01, 32'h4000_0006, 32'h0, 0);
        chk("t4_count7", 64'(count), 7);
        chk("t4_inReady7", 64'(inReady), 0);
        go(0, 0, 2'b00, 0, 0, 1);
        chk("t4_count6", 64'(count), 6);
        go(0, 0, 2'b11, 32'h4000_0007, 32'h4000_0008, 1);
        chk("t4_count_cc", 64'(count), 7);
        chk("t4_lane0_cc", 64'(outInsn[31:0]), 64'h4000_0002);
        ser = 32'h5000_0000;
        for (int c = 0; c < 40; c++) begin
            sz  = mq.size();
            vc  = (sz < DW) ? sz : DW;
            iv  = ((DEPTH - sz) >= FW) ? 2'($urandom_range(0, 3)) : 2'b00;
            acc = 2'($urandom_range(0, vc));
            go(0, 0, iv, ser, ser + 1, acc);
            ser = ser + 2;
        end
        chk("t4_perr_clean", 64'(protocolErr), 0);

        // 5. Flush overrides same-cycle enqueue and dequeue
        go(1, 0, 2'b00, 0, 0, 0);
        go(0, 0, 2'b11, 32'h6000_0000, 32'h6000_0001, 0);
        go(0, 0, 2'b11, 32'h6000_0002, 32'h6000_0003, 0);
        go(0, 0, 2'b01, 32'h6000_0004, 32'h0, 0);
        chk("t5_count5", 64'(count), 5);
        go(0, 1, 2'b11, 32'h6000_0005, 32'h6000_0006, 2);
        chk("t5_count", 64'(count), 0);
        chk("t5_outValid", 64'(outValid), 0);
        chk("t5_perr", 64'(protocolErr), 0);

        // 6. Over-accept is clamped and flagged
        go(0, 0, 2'b01, 32'h7000_0000, 32'h0, 0);
        go(0, 0, 2'b00, 0, 0, 2);
        chk("t6_perr", 64'(protocolErr), 1);
        chk("t6_count", 64'(count), 0);
        go(0, 0, 2'b11, 32'h7000_0001, 32'h7000_0002, 0);
        chk("t6_lane0", 64'(outInsn[31:0]), 64'h7000_0001);
        chk("t6_count2", 64'(count), 2);
        chk("t6_perr_sticky", 64'(protocolErr), 1);
        go(1, 0, 2'b00, 0, 0, 0);
        chk("t6_rst_perr", 64'(protocolErr), 0);
        chk("t6_rst_count", 64'(count), 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
